seq_divider: RTL and testbench

Multi-cycle 32-bit signed/unsigned integer divider for the datapath's DIV operation. It consumes the operand buses and produces quotient and remainder for the LO and HI registers. Internally it iterates restoring division with one trial subtraction per cycle, completing in a fixed 33 cycles after start. The control unit stalls on `busy` and captures results on `done`.

---
 rtl/div_pkg.sv | 25 ++
 rtl/div_trial_sub.sv | 17 +
 rtl/seq_divider.sv | 119 +++++++++++
 tb/tb_seq_divider.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared types and constants for the sequential divider.
package div_pkg;

    localparam int DIV_WIDTH = 32;
    localparam int DIV_ITER  = 32;

    // Quotient reported when the divisor is zero.
    localparam logic [DIV_WIDTH-1:0] DIV_ZERO_QUOTIENT = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } div_state_t;

    // Magnitude of an operand; only signed operands with the top bit set are negated.
    function automatic logic [DIV_WIDTH-1:0] abs_if_signed(
        input logic [DIV_WIDTH-1:0] value,
        input logic                 is_signed
    );
        return (is_signed && value[DIV_WIDTH-1]) ? -value : value;
    endfunction

endpackage

// File: rtl/div_trial_sub.sv
// Combinational trial subtraction for one restoring-division step.
module div_trial_sub
    import div_pkg::*;
#(
    parameter int W = DIV_WIDTH + 1
) (
    input  logic [W-1:0] minuend,
    input  logic [W-1:0] subtrahend,
    output logic [W-1:0] difference,
    output logic         non_negative
);

    // The operands never differ by more than 2^32, so the top bit is a reliable sign.
    assign difference   = minuend - subtrahend;
    assign non_negative = ~difference[W-1];

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle restoring divider: one trial subtraction per cycle, 33 cycles per result.
//
// Handshake: start is sampled only in IDLE, together with is_signed, dividend and
// divisor. busy rises on the accepting edge; done is a one-cycle pulse on which
// quotient, remainder and div_by_zero become valid, and they hold until the next
// accepted start. A start seen while busy is dropped.
module seq_divider
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);

    div_state_t       state;
    logic [4:0]       count;
    logic [WIDTH-1:0] part_rem;   // partial remainder, always below the divisor
    logic [WIDTH-1:0] quo_reg;    // dividend bits shifting out, quotient bits shifting in
    logic [WIDTH-1:0] dvsr;       // divisor magnitude
    logic             quo_neg;
    logic             rem_neg;

    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   trial;
    logic             trial_ok;

    // Next partial remainder candidate: remainder shifted left with the next dividend bit.
    assign shifted = {part_rem, quo_reg[WIDTH-1]};

    div_trial_sub #(.W(WIDTH + 1)) u_trial (
        .minuend      (shifted),
        .subtrahend   ({1'b0, dvsr}),
        .difference   (trial),
        .non_negative (trial_ok)
    );

    // Control FSM and datapath registers with registered outputs.
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state       <= IDLE;
            count       <= '0;
            part_rem    <= '0;
            quo_reg     <= '0;
            dvsr        <= '0;
            quo_neg     <= 1'b0;
            rem_neg     <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        busy <= 1'b1;
                        if (divisor == '0) begin
                            // Divide by zero finishes at once; busy and done share one cycle.
                            done        <= 1'b1;
                            div_by_zero <= 1'b1;
                            quotient    <= DIV_ZERO_QUOTIENT;
                            remainder   <= dividend;
                            state       <= DONE;
                        end else begin
                            div_by_zero <= 1'b0;
                            quo_reg     <= abs_if_signed(dividend, is_signed);
                            dvsr        <= abs_if_signed(divisor, is_signed);
                            quo_neg     <= is_signed & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
                            rem_neg     <= is_signed & dividend[WIDTH-1];
                            part_rem    <= '0;
                            count       <= '0;
                            state       <= RUN;
                        end
                    end
                end
                RUN: begin
                    if (trial_ok) begin
                        part_rem <= trial[WIDTH-1:0];
                    end else begin
                        part_rem <= shifted[WIDTH-1:0];
                    end
                    quo_reg <= {quo_reg[WIDTH-2:0], trial_ok};
                    count   <= count + 5'd1;
                    if (count == 5'(DIV_ITER - 1)) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    // Quotient truncates toward zero; remainder follows the dividend's sign.
                    quotient  <= quo_neg ? -quo_reg  : quo_reg;
                    remainder <= rem_neg ? -part_rem : part_rem;
                    busy      <= 1'b0;
                    done      <= 1'b1;
                    state     <= DONE;
                end
                DONE: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider against an arithmetic reference model.
module tb_seq_divider;

    logic        clock = 1'b0;
    logic        clear = 1'b1;
    logic        start = 1'b0;
    logic        is_signed = 1'b0;
    logic [31:0] dividend = '0;
    logic [31:0] divisor = '0;
    logic        busy;
    logic        done;
    logic        div_by_zero;
    logic [31:0] quotient;
    logic [31:0] remainder;

    int total = 0;
    int bad   = 0;

    // Expected {div_by_zero, quotient, remainder} per issued operation.
    logic [64:0] exp_q[$];

    seq_divider dut (
        .clock       (clock),
        .clear       (clear),
        .start       (start),
        .is_signed   (is_signed),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero),
        .quotient    (quotient),
        .remainder   (remainder)
    );

    // Clock
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [64:0] got, input logic [64:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference: plain integer division semantics, with the two special cases.
    function automatic logic [64:0] model(input bit sgn, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] q;
        logic [31:0] r;
        int sa;
        int sb;
        if (b == 32'd0) return {1'b1, 32'hFFFF_FFFF, a};
        if (!sgn) begin
            q = a / b;
            r = a % b;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = a;
            r = 32'd0;
        end else begin
            sa = a;
            sb = b;
            q = sa / sb;
            r = sa % sb;
        end
        return {1'b0, q, r};
    endfunction

    // mode 0: plain op; mode 1: extra start at cycle 10; mode 2: clear at cycle 10.
    task automatic run_op(input bit sgn, input logic [31:0] a, input logic [31:0] b, input int mode);
        logic [64:0] exp_v;
        int cyc;
        int busy_drop;
        int stray;
        bit seen;
        @(negedge clock);
        is_signed = sgn;
        dividend  = a;
        divisor   = b;
        start     = 1'b1;
        exp_q.push_back(model(sgn, a, b));
        @(negedge clock);
        start    = 1'b0;
        dividend = $urandom;
        divisor  = $urandom;
        cyc = 1;
        seen = 0;
        busy_drop = 0;
        while (cyc <= 60) begin
            if (mode == 2 && cyc == 10) begin
                clear = 1'b1;
                #1;
                check("clear_outputs", {busy, done, div_by_zero, quotient, remainder}, '0);
                void'(exp_q.pop_back());
                @(negedge clock);
                clear = 1'b0;
                stray = 0;
                for (int i = 0; i < 50; i++) begin
                    @(negedge clock);
                    if (done || busy) stray++;
                end
                check("no_done_after_clear", 65'(stray), 65'd0);
                return;
            end
            if (mode == 1) begin
                start     = (cyc == 10);
                is_signed = ~sgn;
                dividend  = 32'd12345;
                divisor   = 32'd3;
            end
            if (done) begin
                seen = 1;
                break;
            end
            if (!busy) busy_drop++;
            @(negedge clock);
            cyc++;
        end
        start = 1'b0;
        check("done_seen", 65'(seen), 65'd1);
        if (!seen) return;
        check("latency", 65'(cyc), (b == 32'd0) ? 65'd1 : 65'd34);
        check("busy_interval", 65'(busy_drop), 65'd0);
        check("busy_at_done", 65'(busy), (b == 32'd0) ? 65'd1 : 65'd0);
        exp_v = exp_q.pop_front();
        check("result", {div_by_zero, quotient, remainder}, exp_v);
        @(negedge clock);
        check("done_pulse", {63'd0, done, busy}, 65'd0);
        check("result_held", {div_by_zero, quotient, remainder}, exp_v);
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 7))
            0: return 32'd0;
            1: return 32'd1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'($urandom_range(0, 20));
            5: return -32'($urandom_range(1, 20));
            default: return $urandom;
        endcase
    endfunction

    // Stimulus and final report.
    initial begin
        repeat (3) @(negedge clock);
        check("reset_outputs", {busy, done, div_by_zero, quotient, remainder}, '0);
        clear = 1'b0;
        @(negedge clock);
        check("idle_after_reset", {busy, done, div_by_zero, quotient, remainder}, '0);

        run_op(1'b0, 32'd100, 32'd7, 0);
        run_op(1'b1, -32'd7, 32'd2, 0);
        run_op(1'b1, 32'd7, -32'd2, 0);
        run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        run_op(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        run_op(1'b0, 32'd5, 32'd0, 0);
        run_op(1'b1, -32'd5, 32'd0, 0);
        run_op(1'b0, 32'd1000, 32'd33, 1);
        run_op(1'b1, -32'd1000, 32'd33, 2);
        run_op(1'b0, 32'd9, 32'd3, 0);

        for (int n = 0; n < 150; n++) begin
            run_op(1'($urandom_range(0, 1)), pick_operand(), pick_operand(), 0);
        end

        check("queue_drained", 65'(exp_q.size()), 65'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
